// File: rtl/dec_pkg.sv
// Shared types, default parameters and the one-hot helper for the 3-to-8 pulse decoder.
package dec_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    localparam int N_IN_DEF      = 3;
    localparam int PULSE_LEN_DEF = 4;

    // Wide enough for any code width up to 8 bits; callers truncate to their own width.
    localparam int ONEHOT_W = 256;

    function automatic logic [ONEHOT_W-1:0] onehot(input logic [7:0] idx);
        return ONEHOT_W'(1) << idx;
    endfunction

endpackage

// File: rtl/pulse_timer.sv
// Pulse-length counter: reloaded on accept, advances while a pulse runs, flags its last cycle.
module pulse_timer #(
    parameter int PULSE_LEN = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic run,
    output logic last
);

    localparam int CW = $clog2(PULSE_LEN + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(PULSE_LEN - 1);

    logic [CW-1:0] count;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    // The counter saturates at its last value instead of wrapping; only a load restarts it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= '0;
        end else if (run && (count != LAST_CNT)) begin
            count <= count + CW'(1);
        end
    end

    assign last = (count == LAST_CNT);

endmodule

// File: rtl/dec_38_pulse.sv
// Sequential 3-to-8 decoder: each accepted code drives its one-hot line for PULSE_LEN cycles.
module dec_38_pulse
    import dec_pkg::*;
#(
    parameter  int N_IN      = N_IN_DEF,
    parameter  int PULSE_LEN = PULSE_LEN_DEF,
    localparam int N_OUT     = 2 ** N_IN
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_IN-1:0]  y,
    input  logic             v,
    input  logic             en,
    input  logic             clr_drop,
    output logic [N_OUT-1:0] d,
    output logic             busy,
    output logic             in_ready,
    output logic             dropped
);

    state_t     state;
    logic       last;
    logic       acc;
    logic       drop_evt;
    logic [N_OUT-1:0] d_next;

    // The timer's last flag is only meaningful while a pulse is running.
    assign in_ready = (state == IDLE) || last;
    assign acc      = v & en & in_ready;
    assign drop_evt = v & en & ~in_ready;
    assign busy     = (state == ACTIVE);
    assign d_next   = N_OUT'(onehot(8'(y)));

    pulse_timer #(
        .PULSE_LEN (PULSE_LEN)
    ) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (acc),
        .run   (state == ACTIVE),
        .last  (last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            d     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (acc) begin
                        d     <= d_next;
                        state <= ACTIVE;
                    end
                end
                ACTIVE: begin
                    // A back-to-back accept on the last cycle reloads d with no zero gap.
                    if (last) begin
                        if (acc) begin
                            d <= d_next;
                        end else begin
                            d     <= '0;
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    d     <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

    // A new drop outranks a simultaneous clear so no overflow event is lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dropped <= 1'b0;
        end else if (drop_evt) begin
            dropped <= 1'b1;
        end else if (clr_drop) begin
            dropped <= 1'b0;
        end
    end

endmodule

// File: tb/tb_dec_38_pulse.sv
// Self-checking bench for dec_38_pulse: directed vector table, hand sequences, random vs. model.
module tb_dec_38_pulse;

    localparam int PULSE_LEN = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] y;
    logic       v, en, clr_drop;
    logic [7:0] d;
    logic       busy, in_ready, dropped;

    dec_38_pulse #(
        .N_IN      (3),
        .PULSE_LEN (PULSE_LEN)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .y        (y),
        .v        (v),
        .en       (en),
        .clr_drop (clr_drop),
        .d        (d),
        .busy     (busy),
        .in_ready (in_ready),
        .dropped  (dropped)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: remaining high cycles of the current pulse, its value, sticky flag.
    int         m_rem;
    logic [7:0] m_d;
    logic       m_drop;
    logic       m_rdy_pre;
    logic       rdy_pre;

    typedef struct {
        logic [2:0] y;
        logic       v;
        logic       en;
        logic       clr;
        logic       rdy;
        logic [7:0] d;
        logic       drop;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic [2:0] ty, logic tv, logic ten, logic tclr,
                                logic trdy, logic [7:0] td, logic tdrop);
        vec_t r;
        r.y = ty; r.v = tv; r.en = ten; r.clr = tclr;
        r.rdy = trdy; r.d = td; r.drop = tdrop;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_rem  = 0;
        m_d    = '0;
        m_drop = 1'b0;
    endtask

    task automatic model_edge(input logic [2:0] ty, input logic tv, input logic ten, input logic tclr);
        logic rdy;
        rdy = (m_rem <= 1);
        if (tv && ten && !rdy) m_drop = 1'b1;
        else if (tclr)         m_drop = 1'b0;
        if (tv && ten && rdy) begin
            m_d   = 8'd1 << ty;
            m_rem = PULSE_LEN;
        end else if (m_rem > 0) begin
            m_rem--;
            if (m_rem == 0) m_d = '0;
        end
    endtask

    // Drive inputs on the falling edge, sample in_ready before the rising edge, outputs 1 ns after.
    task automatic apply(input logic [2:0] ty, input logic tv, input logic ten, input logic tclr);
        @(negedge clk);
        y = ty; v = tv; en = ten; clr_drop = tclr;
        #1;
        rdy_pre   = in_ready;
        m_rdy_pre = (m_rem <= 1);
        @(posedge clk);
        model_edge(ty, tv, ten, tclr);
        #1;
    endtask

    task automatic compare_model(input string tag);
        check({tag, ".in_ready"}, 32'(rdy_pre), 32'(m_rdy_pre));
        check({tag, ".d"},        32'(d),       32'(m_d));
        check({tag, ".busy"},     32'(busy),    32'(m_d != 0));
        check({tag, ".dropped"},  32'(dropped), 32'(m_drop));
        check({tag, ".onehot"},   32'($countones(d) <= 1), 32'(1));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        y = '0; v = 1'b0; en = 1'b0; clr_drop = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        y = '0; v = 1'b0; en = 1'b0; clr_drop = 1'b0;
        model_reset();
        #12;
        check("reset.d",        32'(d),        32'(0));
        check("reset.busy",     32'(busy),     32'(0));
        check("reset.dropped",  32'(dropped),  32'(0));
        check("reset.in_ready", 32'(in_ready), 32'(1));
        @(negedge clk);
        rst_n = 1'b1;

        // Single pulse y=5
        tbl.push_back(mk(3'd5, 1, 1, 0, 1, 8'h20, 0));
        tbl.push_back(mk(3'd0, 0, 1, 0, 0, 8'h20, 0));
        tbl.push_back(mk(3'd0, 0, 1, 0, 0, 8'h20, 0));
        tbl.push_back(mk(3'd0, 0, 1, 0, 0, 8'h20, 0));
        tbl.push_back(mk(3'd0, 0, 1, 0, 1, 8'h00, 0));
        tbl.push_back(mk(3'd0, 0, 1, 0, 1, 8'h00, 0));
        // Back-to-back y=2 then y=6 on the 4th cycle
        tbl.push_back(mk(3'd2, 1, 1, 0, 1, 8'h04, 0));
        tbl.push_back(mk(3'd0, 0, 1, 0, 0, 8'h04, 0));
        tbl.push_back(mk(3'd0, 0, 1, 0, 0, 8'h04, 0));
        tbl.push_back(mk(3'd0, 0, 1, 0, 0, 8'h04, 0));
        tbl.push_back(mk(3'd6, 1, 1, 0, 1, 8'h40, 0));
        tbl.push_back(mk(3'd0, 0, 1, 0, 0, 8'h40, 0));
        tbl.push_back(mk(3'd0, 0, 1, 0, 0, 8'h40, 0));
        tbl.push_back(mk(3'd0, 0, 1, 0, 0, 8'h40, 0));
        tbl.push_back(mk(3'd0, 0, 1, 0, 1, 8'h00, 0));
        // Drop: y=1 accepted, y=4 on the 2nd cycle, then clear; then clear racing a drop
        tbl.push_back(mk(3'd1, 1, 1, 0, 1, 8'h02, 0));
        tbl.push_back(mk(3'd0, 0, 1, 0, 0, 8'h02, 0));
        tbl.push_back(mk(3'd4, 1, 1, 0, 0, 8'h02, 1));
        tbl.push_back(mk(3'd0, 0, 1, 0, 0, 8'h02, 1));
        tbl.push_back(mk(3'd0, 0, 1, 0, 1, 8'h00, 1));
        tbl.push_back(mk(3'd0, 0, 1, 0, 1, 8'h00, 1));
        tbl.push_back(mk(3'd0, 0, 1, 1, 1, 8'h00, 0));
        tbl.push_back(mk(3'd3, 1, 1, 0, 1, 8'h08, 0));
        tbl.push_back(mk(3'd0, 1, 1, 1, 0, 8'h08, 1));
        tbl.push_back(mk(3'd0, 0, 1, 1, 0, 8'h08, 0));
        tbl.push_back(mk(3'd0, 0, 1, 0, 0, 8'h08, 0));
        tbl.push_back(mk(3'd0, 0, 1, 0, 1, 8'h00, 0));
        // Gating: en low in IDLE, then en low mid-pulse
        tbl.push_back(mk(3'd7, 1, 0, 0, 1, 8'h00, 0));
        tbl.push_back(mk(3'd7, 1, 1, 0, 1, 8'h80, 0));
        tbl.push_back(mk(3'd7, 1, 0, 0, 0, 8'h80, 0));
        tbl.push_back(mk(3'd7, 1, 0, 0, 0, 8'h80, 0));
        tbl.push_back(mk(3'd7, 1, 0, 0, 0, 8'h80, 0));
        tbl.push_back(mk(3'd7, 1, 0, 0, 1, 8'h00, 0));
        tbl.push_back(mk(3'd0, 0, 0, 0, 1, 8'h00, 0));

        foreach (tbl[i]) begin
            apply(tbl[i].y, tbl[i].v, tbl[i].en, tbl[i].clr);
            check($sformatf("tbl%0d.in_ready", i), 32'(rdy_pre), 32'(tbl[i].rdy));
            check($sformatf("tbl%0d.d", i),        32'(d),       32'(tbl[i].d));
            check($sformatf("tbl%0d.busy", i),     32'(busy),    32'(tbl[i].d != 0));
            check($sformatf("tbl%0d.dropped", i),  32'(dropped), 32'(tbl[i].drop));
        end

        // Sweep every code, each presented only once the block is ready again.
        for (int k = 0; k < 8; k++) begin
            apply(3'(k), 1'b1, 1'b1, 1'b0);
            check($sformatf("sweep%0d.d", k), 32'(d), 32'(1) << k);
            compare_model($sformatf("sweep%0d", k));
            for (int c = 0; c < PULSE_LEN; c++) begin
                apply(3'd0, 1'b0, 1'b1, 1'b0);
                compare_model($sformatf("sweep%0d_%0d", k, c));
            end
        end

        // Reset mid-pulse: outputs clear without a clock edge.
        apply(3'd3, 1'b1, 1'b1, 1'b0);
        apply(3'd0, 1'b0, 1'b1, 1'b0);
        apply(3'd1, 1'b1, 1'b1, 1'b0);
        check("pre_rst.d",       32'(d),       32'(8'h08));
        check("pre_rst.dropped", 32'(dropped), 32'(1));
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst.d",       32'(d),       32'(0));
        check("async_rst.busy",    32'(busy),    32'(0));
        check("async_rst.dropped", 32'(dropped), 32'(0));
        model_reset();
        y = '0; v = 1'b0; en = 1'b0; clr_drop = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        apply(3'd4, 1'b1, 1'b1, 1'b0);
        check("post_rst.d0", 32'(d), 32'(8'h10));
        for (int c = 1; c < PULSE_LEN; c++) begin
            apply(3'd0, 1'b0, 1'b1, 1'b0);
            check($sformatf("post_rst.d%0d", c), 32'(d), 32'(8'h10));
        end
        apply(3'd0, 1'b0, 1'b1, 1'b0);
        check("post_rst.end", 32'(d), 32'(0));

        // Random traffic against the model.
        do_reset();
        for (int n = 0; n < 400; n++) begin
            apply(3'($urandom_range(0, 7)),
                  1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 9) < 8),
                  1'($urandom_range(0, 9) == 0));
            compare_model($sformatf("rnd%0d", n));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/dec_38_pulse.md
Name: dec_38_pulse

Overview:
- Sequential 3-to-8 decoder; receiving end of the 8:3 priority encoder's (y, v) interface.
- Accepts an encoded channel index with its valid bit and drives the matching one-hot output line.
- Each accepted code produces a registered pulse of programmable length.
- Codes arriving while a pulse is in flight are dropped and flagged in a sticky status bit.

Parameters:
- N_IN, 3, code width; output width N_OUT = 2**N_IN is a derived localparam, not overridable.
- PULSE_LEN, 4, cycles each decoded line stays high; legal range 1..255.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- y  input  N_IN  encoded channel index.
- v  input  1  code valid, the encoder's valid output.
- en  input  1  acceptance enable; gates new captures only.
- clr_drop  input  1  synchronous clear of the dropped flag.
- d  output  N_OUT  registered one-hot decoded line.
- busy  output  1  high while a pulse is in flight.
- in_ready  output  1  combinational; high when a code would be accepted this cycle.
- dropped  output  1  sticky; a valid code was presented while not ready.

Behaviour:
- Reset (async assert, sync release): d=0, busy=0, dropped=0, FSM=IDLE, count=0.
- Accept condition: acc = v & en & in_ready.
- FSM IDLE:
  - in_ready=1.
  - On acc, the next edge loads d <= 1<<y and count <= 0, and the FSM moves to ACTIVE.
  - Latency is one cycle from the accepting edge to d.
- FSM ACTIVE:
  - busy=1; d holds its one-hot value; count increments each cycle.
  - in_ready = (count == PULSE_LEN-1).
  - At the last cycle without acc: d <= 0 and the FSM returns to IDLE.
  - At the last cycle with acc (back-to-back): d loads the new one-hot directly, count <= 0, and the FSM stays in ACTIVE, so d never carries a zero gap.
- Pulse width: each accepted code gives d exactly PULSE_LEN consecutive cycles high.
- PULSE_LEN=1: in_ready is 1 in every ACTIVE cycle, so the block accepts a new code every cycle.
- en low during ACTIVE: the pulse runs to completion; en only blocks new acceptance.
- v low or en low in IDLE: nothing is captured, d stays 0, dropped is unchanged.
- Drop: v & en & ~in_ready sets dropped on the next edge. The dropped code is discarded, not queued.
- dropped is cleared only by clr_drop or reset.
- Simultaneous clr_drop and a new drop event in the same cycle: set wins, so dropped = 1.
- Invariant: d is always zero or one-hot.
- Invariant: busy = (d != 0).
- y = 0 with v = 1 is a legal code and gives d = 8'b0000_0001.
- Reset asserted mid-pulse: d clears immediately, without waiting for a clock edge.
- Counter width: $clog2(PULSE_LEN+1). The counter never wraps; it is reloaded on accept.

Decomposition:
- Shared package dec_pkg holds:
  - the state enum {IDLE, ACTIVE};
  - the localparams N_IN_DEF=3 and PULSE_LEN_DEF=4;
  - the function onehot(idx) returning 1<<idx.
- One natural sub-module, pulse_timer: the count register plus its last-cycle compare. It takes load/run and PULSE_LEN, and outputs last.
- Decode and hold registers stay in the top.

Test Plan:
- Reset, then y=3'd5, v=1, en=1 for one cycle -> d=8'b0010_0000 starting one cycle later for exactly 4 cycles, then d=0; busy tracks d; in_ready returns to 1.
- Sweep y=0..7, each held until in_ready=1 -> every d is the matching one-hot (y=0 gives 0x01, y=7 gives 0x80); dropped stays 0.
- Back-to-back: y=2 accepted, then y=6 presented on the pulse's 4th cycle -> d goes 0x04 for 4 cycles then 0x40 for 4 cycles with no zero cycle between.
- Drop: y=1 accepted, then y=4 with v=1 on the pulse's 2nd cycle -> d stays 0x02 for its full 4 cycles; 0x10 never appears; dropped=1 until clr_drop; clr_drop together with another drop leaves dropped=1.
- Gating: v=1, en=0 in IDLE -> d=0, dropped=0. en dropped low mid-pulse -> the pulse still completes its 4 cycles.
- Reset mid-pulse: rst_n low while d=0x08 -> d=0, busy=0, dropped=0 with no clock edge required. After release, the first code gives a full 4-cycle pulse.
